// File: rtl/jk_input_conditioner.sv
// Two-channel synchronizer/debouncer producing j/k request pulses for the j/k Moore FSM.
// Build option: JK_INPUT_CONDITIONER_MUTEX_EN suppresses j and k when both would fire in the same cycle.
//
// Per-channel debounce phase (decoded each edge from s2 vs db):
//   state       | meaning
//   ST_STABLE   | synchronized sample matches debounced level; counter held at 0
//   ST_CHANGING | sample differs from level; counting toward acceptance
module jk_input_conditioner #(
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic areset,
  input  logic btn_on,
  input  logic btn_off,
  output logic j,
  output logic k,
  output logic on_lvl,
  output logic off_lvl
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } phase_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] rise;
  logic [1:0] lvl;
  logic       pulse_j;
  logic       pulse_k;

  assign raw = {btn_off, btn_on};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic             s1;
    logic             s2;
    logic             db;
    logic             db_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    phase_t           phase;

    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        cnt <= '0;
        db  <= 1'b0;
      end else begin
        s1  <= raw[ch];
        s2  <= s1;
        cnt <= cnt_next;
        db  <= db_next;
      end
    end

    // Any sample equal to the current level restarts the count (glitch rejection).
    always_comb begin
      phase    = (s2 == db) ? ST_STABLE : ST_CHANGING;
      db_next  = db;
      cnt_next = '0;
      case (phase)
        ST_STABLE: begin
          cnt_next = '0;
        end
        ST_CHANGING: begin
          if (cnt == CNT_MAX) begin
            db_next  = s2;
            cnt_next = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          db_next  = db;
          cnt_next = '0;
        end
      endcase
    end

    assign rise[ch] = db_next & ~db;
    assign lvl[ch]  = db;
  end

`ifdef JK_INPUT_CONDITIONER_MUTEX_EN
  // A coincident press on both buttons is ambiguous; drop both requests for that cycle.
  assign pulse_j = rise[0] & ~rise[1];
  assign pulse_k = rise[1] & ~rise[0];
`else
  assign pulse_j = rise[0];
  assign pulse_k = rise[1];
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      j <= 1'b0;
      k <= 1'b0;
    end else begin
      j <= pulse_j;
      k <= pulse_k;
    end
  end

  assign on_lvl  = lvl[0];
  assign off_lvl = lvl[1];

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed self-checking bench for jk_input_conditioner with DEBOUNCE_CYCLES=4.
// Honours JK_INPUT_CONDITIONER_MUTEX_EN for the simultaneous-press expectations.
module tb_jk_input_conditioner;

  logic clk;
  logic areset;
  logic btn_on;
  logic btn_off;
  logic j;
  logic k;
  logic on_lvl;
  logic off_lvl;

  int tests;
  int failures;

  jk_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .areset  (areset),
    .btn_on  (btn_on),
    .btn_off (btn_off),
    .j       (j),
    .k       (k),
    .on_lvl  (on_lvl),
    .off_lvl (off_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s[%0d]: observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] bounce;
    logic       simul_pulse;
    tests    = 0;
    failures = 0;
    bounce   = 8'b1111_0111;  // bit i applied before edge i: 1,1,1,0,1,1,1,1
`ifdef JK_INPUT_CONDITIONER_MUTEX_EN
    simul_pulse = 1'b0;
`else
    simul_pulse = 1'b1;
`endif

    areset  = 1'b1;
    btn_on  = 1'b0;
    btn_off = 1'b0;
    tick();
    tick();
    chk("rst_j", 0, j, 1'b0);
    chk("rst_on_lvl", 0, on_lvl, 1'b0);
    areset = 1'b0;

    // Press held; tick n lands just after edge n-1, so acceptance shows at tick 6.
    btn_on = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("press0_j", n, j, n == 6);
      chk("press0_on_lvl", n, on_lvl, n >= 6);
    end

    // Asynchronous reset between edges with btn_on still high.
    #2 areset = 1'b1;
    #1;
    chk("arst_on_lvl", 0, on_lvl, 1'b0);
    chk("arst_j", 0, j, 1'b0);
    chk("arst_k", 0, k, 1'b0);
    chk("arst_off_lvl", 0, off_lvl, 1'b0);
    tick();
    areset = 1'b0;
    for (int n = 1; n <= 3; n++) tick();
    // Reset again mid-debounce: partial count must be discarded.
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("rst_rel_j", n, j, n == 6);
      chk("rst_rel_on_lvl", n, on_lvl, n >= 6);
    end

    // Release: level falls after the same latency, no pulse.
    btn_on = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("release_on_lvl", n, on_lvl, n < 6);
      chk("release_j", n, j, 1'b0);
    end

    // Clean second press held 20 cycles: exactly one j pulse, no k.
    btn_on = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk("clean_j", n, j, n == 6);
      chk("clean_k", n, k, 1'b0);
      chk("clean_on_lvl", n, on_lvl, n >= 6);
    end
    btn_on = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    chk("clean_rel_on_lvl", 0, on_lvl, 1'b0);

    // Bounce on btn_off: count restarts at the 0, acceptance 4 samples later at tick 10.
    for (int n = 1; n <= 14; n++) begin
      btn_off = (n <= 8) ? bounce[n-1] : 1'b1;
      tick();
      chk("bounce_k", n, k, n == 10);
      chk("bounce_off_lvl", n, off_lvl, n >= 10);
      chk("bounce_j", n, j, 1'b0);
    end
    btn_off = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("bounce_rel_off_lvl", n, off_lvl, n < 6);
      chk("bounce_rel_k", n, k, 1'b0);
    end

    // Short glitch of two cycles is rejected.
    btn_on = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      if (n == 3) btn_on = 1'b0;
      tick();
      chk("glitch_on_lvl", n, on_lvl, 1'b0);
      chk("glitch_j", n, j, 1'b0);
    end

    // Simultaneous press on both channels.
    btn_on  = 1'b1;
    btn_off = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk("simul_j", n, j, (n == 6) & simul_pulse);
      chk("simul_k", n, k, (n == 6) & simul_pulse);
      chk("simul_on_lvl", n, on_lvl, n >= 6);
      chk("simul_off_lvl", n, off_lvl, n >= 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
